// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encoding and frame geometry constants.
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR0 = 3'd0;
  localparam state_t ST_HDR1 = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler for the program loader.
// Holds three bytes; the fourth arrives on din and completes the word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word_out,
  output logic        word_done
);

  logic [23:0] r_buf;
  logic [1:0]  r_idx;

  assign word_out  = {din, r_buf};
  assign word_done = push && (r_idx == 2'(WORD_BYTES - 1));

  // Shift bytes in from the top so the first byte lands in bits [7:0].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (push) begin
      r_buf <= {din, r_buf[23:8]};
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: header, word assembly, imem writes.
// Keeps the core in reset until the whole frame has been written.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  output logic              loaded,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [ADDR_W:0] r_widx;

  logic        w_xfer;
  logic [15:0] w_n;
  logic        w_push;
  logic        w_clear;
  logic [31:0] w_word;
  logic        w_word_done;
  logic        w_last;

  assign s_ready = (r_state == ST_HDR0) ||
                   (r_state == ST_HDR1) ||
                   (r_state == ST_DATA);

  assign w_xfer  = s_valid && s_ready;
  assign w_n     = {s_data, r_cnt[7:0]};
  assign w_push  = w_xfer && (r_state == ST_DATA);
  assign w_clear = w_xfer && (r_state == ST_HDR1);
  assign w_last  = {{(15 - ADDR_W){1'b0}}, r_widx}
                   == (r_cnt - 16'd1);

  byte_packer u_pack (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (w_clear),
    .push      (w_push),
    .din       (s_data),
    .word_out  (w_word),
    .word_done (w_word_done)
  );

  // Frame FSM with registered memory-write and core-control outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_HDR0;
      r_cnt    <= '0;
      r_widx   <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_rstn <= 1'b0;
      loaded   <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      unique case (r_state)
        ST_HDR0: begin
          if (w_xfer) begin
            r_cnt[7:0] <= s_data;
            r_state    <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_xfer) begin
            r_cnt[15:8] <= s_data;
            r_widx      <= '0;
            if (w_n == 16'd0) begin
              r_state  <= ST_DONE;
              cpu_rstn <= 1'b1;
              loaded   <= 1'b1;
            end else if (w_n > 16'(DEPTH)) begin
              r_state <= ST_ERR;
              err     <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_done) begin
            im_we    <= 1'b1;
            im_wdata <= w_word;
            im_addr  <= r_widx[ADDR_W-1:0];
            r_widx   <= r_widx + 1'b1;
            if (w_last) begin
              r_state  <= ST_DONE;
              cpu_rstn <= 1'b1;
              loaded   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (reload) begin
            r_state  <= ST_HDR0;
            cpu_rstn <= 1'b0;
            loaded   <= 1'b0;
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_HDR0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random programs against a word-level model.
// The bench owns the instruction memory and compares it with the model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        reload;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rstn;
  logic        loaded;
  logic        err;

  int nchk = 0;
  int npass = 0;
  int cyc = 0;

  logic [31:0] prog [64];
  logic [31:0] mem  [64];
  logic [31:0] mmem [64];
  logic [37:0] wq [$];
  int          tq [$];
  logic [1:0]  cq [$];
  logic [37:0] exq [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .reload   (reload),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rstn (cpu_rstn),
    .loaded   (loaded),
    .err      (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // The memory itself: every strobe is logged and written here.
  always @(negedge clk) begin
    if (rstn && im_we) begin
      wq.push_back({im_addr, im_wdata});
      tq.push_back(cyc);
      cq.push_back({cpu_rstn, loaded});
      mem[im_addr] = im_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk = nchk + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      k++;
      if (k > 40) begin
        check("ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wq.delete();
    tq.delete();
    cq.delete();
    exq.delete();
  endtask

  // mode: 0 continuous, 1 alternate gaps, 2 random gaps
  task automatic send_frame(input int n, input int mode);
    logic [15:0] nn;
    logic [31:0] w;
    bit g;
    clear_log();
    nn = 16'(n);
    for (int i = 0; i < n; i++) begin
      exq.push_back({6'(i), prog[i]});
      mmem[i] = prog[i];
    end
    g = (mode == 1);
    send_byte(nn[7:0], g);
    send_byte(nn[15:8], g);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) begin
        if (i == n - 1 && b == 3)
          check("cpu_rstn_low_in_load", cpu_rstn, 0);
        if (mode == 2) g = bit'($urandom % 2);
        send_byte(w[8*b +: 8], g);
      end
    end
    check("loaded_at_end", {cpu_rstn, loaded}, 2'b11);
  endtask

  task automatic verify(input int n, input int spacing);
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("write_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      check("write_addr_data", wq[i], exq[i]);
      check("ctl_at_write", cq[i], (i == n - 1) ? 2'b11 : 2'b00);
      if (spacing > 0 && i > 0)
        check("write_spacing", tq[i] - tq[i-1], spacing);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== mmem[i]) bad++;
    check("mem_image", bad, 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_cpu_rstn", cpu_rstn, 0);
    check("reload_loaded", loaded, 0);
    check("reload_ready", s_ready, 1);
  endtask

  task automatic gen_prog(input int n);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = '0;
      mmem[i] = '0;
    end
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    reload  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", s_ready, 1);
    check("rst_we", im_we, 0);
    check("rst_addr", im_addr, 0);
    check("rst_wdata", im_wdata, 0);
    check("rst_cpu_rstn", cpu_rstn, 0);
    check("rst_loaded", loaded, 0);
    check("rst_err", err, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // directed three-instruction program, back to back
    prog[0] = 32'h0010_0093;
    prog[1] = 32'h0020_0113;
    prog[2] = 32'h0021_01b3;
    send_frame(3, 0);
    verify(3, 4);

    // same program, valid toggling every other cycle
    pulse_reload();
    send_frame(3, 1);
    verify(3, 8);

    // empty program
    pulse_reload();
    clear_log();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("n0_loaded", loaded, 1);
    check("n0_cpu_rstn", cpu_rstn, 1);
    check("n0_ready", s_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("n0_no_writes", wq.size(), 0);

    // random programs and stall patterns
    for (int r = 0; r < 3; r++) begin
      pulse_reload();
      n = $urandom_range(1, 64);
      gen_prog(n);
      send_frame(n, 2);
      verify(n, 0);
    end

    // full memory, then a one-word reload
    pulse_reload();
    gen_prog(64);
    send_frame(64, 0);
    verify(64, 4);
    check("full_last_addr", wq[63][37:32], 63);
    pulse_reload();
    prog[0] = 32'h0000_0013;
    send_frame(1, 0);
    verify(1, 0);

    // oversize header is a sticky error
    pulse_reload();
    clear_log();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    check("err_flag", err, 1);
    check("err_ready", s_ready, 0);
    check("err_cpu_rstn", cpu_rstn, 0);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("err_sticky", {err, s_ready}, 2'b10);
    check("err_no_writes", wq.size(), 0);
    rstn = 1'b0;
    #1;
    check("err_rst_err", err, 0);
    check("err_rst_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // reset in the middle of a load
    gen_prog(3);
    clear_log();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 5; b++) begin
      if (b < 4) send_byte(prog[0][8*b +: 8], 1'b0);
      else send_byte(prog[1][7:0], 1'b0);
    end
    mmem[0] = prog[0];
    rstn = 1'b0;
    #1;
    check("mid_rst_wdata", im_wdata, 0);
    check("mid_rst_we", im_we, 0);
    check("mid_rst_addr", im_addr, 0);
    check("mid_rst_ctl", {cpu_rstn, loaded, err}, 3'b000);
    check("mid_rst_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    gen_prog(3);
    send_frame(3, 0);
    verify(3, 4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the pipelined RISC-V core: the write side of instruction memory, in silicon rather than in simulation. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory ROM at consecutive word addresses. It holds the core in reset until the load completes, then releases it so execution starts at PC 0.

## Interface
- ADDR_W, default 6: instruction-memory word-address width; DEPTH = 2**ADDR_W words (64 words, byte addresses 0x000-0x0FF).
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  1  byte stream valid.
- s_data  in  8  byte stream data.
- s_ready  out  1  loader can accept a byte; a byte transfers when s_valid && s_ready at a rising edge.
- reload  in  1  single-cycle request to start a new load; honoured only in DONE.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word address of the current write.
- im_wdata  out  32  instruction word to write.
- cpu_rstn  out  1  active-low reset to the core; low throughout a load.
- loaded  out  1  high in DONE.
- err  out  1  high in ERR.

## Operation
- Frame format: 2-byte word count N (little-endian, 16 bits), then 4*N instruction bytes, each word little-endian (byte 0 = instr[7:0]).
- States: HDR0, HDR1, DATA, DONE, ERR. Reset enters HDR0.
- HDR0: accept a byte into cnt[7:0], then go to HDR1.
- HDR1: accept a byte into cnt[15:8]. The next state is taken from N = {s_data, cnt[7:0]}:
  - N == 0 goes to DONE.
  - N > DEPTH goes to ERR.
  - Otherwise go to DATA, with word index 0 and byte index 0.
- DATA: each accepted byte shifts into a 24-bit buffer and byte index increments mod 4. On the 4th byte:
  - register im_wdata = {s_data, buf[23:0]}, im_addr = word index, and im_we = 1 for exactly one cycle;
  - word index increments;
  - if word index == N-1, go to DONE.
- DONE: cpu_rstn = 1, loaded = 1, s_ready = 0. Extra s_valid bytes are not consumed. reload = 1 goes to HDR0, and cpu_rstn drops on the same edge.
- ERR: sticky until rstn. s_ready = 0, cpu_rstn = 0, err = 1, no memory writes.
- s_ready is decoded from state: 1 in HDR0, HDR1 and DATA; 0 otherwise.
- Arithmetic: word index is ADDR_W+1 bits and is compared against the 16-bit N zero-extended. N == DEPTH is legal and fills memory exactly.
- Memory words beyond N keep their previous contents.

## Timing
- Reset values: state HDR0, s_ready 1 (decoded), im_we 0, im_addr 0, im_wdata 0, cpu_rstn 0, loaded 0, err 0.
- Throughput: one byte per cycle when s_valid stays high. There are no bubbles, and s_ready never drops between words.
- im_we asserts the cycle after the edge that accepted the word's 4th byte. The next byte is accepted in that same cycle without disturbing im_wdata.
- cpu_rstn rises on the same edge as the final im_we pulse. The memory write lands on that edge, so the core's first fetch (the next cycle) sees the new word.
- Gaps in s_valid stall all counters; no state advances without a transfer.
- Reset mid-load: outputs return to reset values immediately (asynchronous). Partially written memory is left as-is, and the next frame restarts from HDR0.
- reload asserted outside DONE is ignored.

## Structure
- Shared package `loader_pkg` holds:
  - state encoding localparams (ST_HDR0..ST_ERR, 3 bits);
  - HDR_BYTES = 2;
  - WORD_BYTES = 4.
- One sub-module, `byte_packer`: the 24-bit shift buffer and 2-bit byte index. Interface: clk, rstn, clear, push, din[7:0], word_out[31:0], word_done. word_done is a combinational flag for push on index 3.
- The FSM, address counter and output registers stay in imem_loader.

## Test plan
- Load N=3 (bytes 03 00, then 93 00 10 00 / 13 01 20 00 / b3 01 21 00), s_valid continuously high:
  - exactly three im_we pulses at addr 0, 1, 2 with data 0x00100093, 0x00200113, 0x002101b3;
  - cpu_rstn and loaded rise on the 3rd write edge.
- Same frame with s_valid toggled every other cycle: identical writes and values, writes spaced 8 cycles apart, no lost or duplicated bytes.
- Header 00 00: DONE the cycle after the 2nd byte, no im_we, cpu_rstn = 1.
- Header 41 00 (N=65 > 64): ERR after the 2nd byte; err = 1, s_ready = 0, cpu_rstn = 0, no writes. Pulsing reload leaves it in ERR; rstn low recovers it to HDR0.
- N=64 full load: last write at addr 63, then DONE. Pulse reload, send N=1 word 0x00000013: write at addr 0, cpu_rstn low for the whole reload, then high.
- Assert rstn low after 5 data bytes of an N=3 load: all outputs return to reset values at once. A fresh full frame afterwards loads correctly from addr 0.
